// File: rtl/sd_seq_check_if.sv
// rtl/sd_seq_check_if.sv - consumer-side srdy/drdy data handshake bundle for sd_seq_check
interface sd_seq_check_if #(
    parameter int width = 8
);
    logic             c_srdy;
    logic             c_drdy;
    logic [width-1:0] c_data;

    // producer drives data and srdy, sees drdy
    modport master (
        output c_srdy,
        output c_data,
        input  c_drdy
    );

    // checker consumes data and srdy, drives drdy
    modport slave (
        input  c_srdy,
        input  c_data,
        output c_drdy
    );
endinterface

// File: rtl/sd_seq_check.sv
// rtl/sd_seq_check.sv - incrementing-sequence stream checker with throttled drdy (optional SD_SEQ_CHECK_LFSR_EN)
module sd_seq_check #(
    parameter int width   = 8,
    parameter int pat_dep = 8
) (
    input  logic                clk,
    input  logic                reset,
    sd_seq_check_if.slave       c_if,
    input  logic                start,
    input  logic [31:0]         count,
    input  logic [pat_dep-1:0]  drdy_pat,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic [31:0]         word_count
);
    localparam int pw = (pat_dep > 1) ? $clog2(pat_dep) : 1;
    localparam logic [pw-1:0] ptr_last = pw'(pat_dep - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [pw-1:0]    ptr;
    logic [31:0]      remaining;
    logic [width-1:0] expected;
    logic             pat_bit;
    logic             xfer;

`ifdef SD_SEQ_CHECK_LFSR_EN
    logic [15:0] lfsr;
    logic        lfsr_fb;

    // taps 16,14,13,11 in right-shifting Fibonacci form; bit 0 is the throttle
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign pat_bit = lfsr[0];

    // LFSR reloads its seed on reset and steps on every RUN cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (state == RUN) begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
        end
    end
`else
    assign pat_bit = drdy_pat[ptr];
`endif

    // drdy only in RUN, gated by the current throttle bit
    assign c_if.c_drdy = (state == RUN) & pat_bit;
    assign xfer        = c_if.c_srdy & c_if.c_drdy;

    // command FSM, sequence check and counters; busy/done are registered from next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            remaining  <= '0;
            expected   <= width'(1);
            err_count  <= '0;
            word_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            busy <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != 32'd0) begin
                            remaining <= count;
                            state     <= RUN;
                            busy      <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // throttle pointer free-runs through RUN regardless of transfers
                    ptr <= (ptr == ptr_last) ? '0 : ptr + pw'(1);
                    if (xfer) begin
                        remaining  <= remaining - 32'd1;
                        word_count <= word_count + 32'd1;
                        // a match or a resync both make the next expected word data+1
                        expected   <= c_if.c_data + width'(1);
                        if ((c_if.c_data != expected) && (err_count != 16'hFFFF)) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (remaining == 32'd1) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sd_seq_check.sv
// tb/tb_sd_seq_check.sv - scoreboard bench for sd_seq_check
module tb_sd_seq_check;
    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] count;
    logic [7:0]  drdy_pat;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [31:0] word_count;

    sd_seq_check_if #(.width(8)) bus ();

    sd_seq_check #(.width(8), .pat_dep(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .c_if       (bus),
        .start      (start),
        .count      (count),
        .drdy_pat   (drdy_pat),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .word_count (word_count)
    );

    typedef struct {
        logic [7:0]  w;
        logic [15:0] err;
        logic [31:0] wc;
    } sb_t;

    sb_t        sb[$];
    logic [7:0] tx_words[$];
    sb_t        pend;
    bit         pending;
    int         checks;
    int         errors;
    logic [7:0]  m_exp;
    logic [15:0] m_err;
    logic [31:0] m_wc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_word(input logic [7:0] w);
        sb_t e;
        if (w != m_exp && m_err != 16'hFFFF) m_err++;
        m_exp = w + 8'd1;
        m_wc++;
        e.w = w;
        e.err = m_err;
        e.wc = m_wc;
        sb.push_back(e);
        tx_words.push_back(w);
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_drdy"}, 64'(bus.c_drdy), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err_count), 64'd0);
        check({tag, "_wc"}, 64'(word_count), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b0;
        bus.c_srdy = 1'b0;
        sb.delete();
        tx_words.delete();
        m_exp = 8'd1;
        m_err = 16'd0;
        m_wc = 32'd0;
        @(negedge clk);
        check("rst_done_low", 64'(done), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // issues a command and feeds tx_words; stops feeding after stop words
    task automatic run_cmd(input int n, input int stop, input bit stall, input bit alt,
                           input bit dbl, output int cycles);
        int idx;
        @(posedge clk); #1;
        start = 1'b1;
        count = 32'(n);
        bus.c_srdy = 1'b0;
        @(posedge clk); #1;
        start = dbl;
        count = dbl ? 32'd10 : 32'd0;
        if (dbl) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        idx = 0;
        cycles = 0;
        while (idx < stop && cycles < 300) begin
            bus.c_data = tx_words[idx];
            bus.c_srdy = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(negedge clk);
            cycles++;
            if (alt) check("drdy_alt", 64'(bus.c_drdy), 64'(cycles % 2));
            if (bus.c_srdy && bus.c_drdy) idx++;
            if (idx < stop) begin
                @(posedge clk); #1;
            end
        end
        if (cycles >= 300) check("xfer_timeout", 64'(idx), 64'(stop));
        tx_words.delete();
        @(posedge clk); #1;
        bus.c_srdy = 1'b0;
        if (stop == n) begin
            @(negedge clk);
            check("done_pulse", 64'(done), 64'd1);
            check("drdy_after_last", 64'(bus.c_drdy), 64'd0);
            check("busy_after_last", 64'(busy), 64'd0);
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
        end
    endtask

    // scoreboard monitor: pops an entry per transfer, checks counters after the edge
    always @(negedge clk) begin
        if (pending) begin
            check("err_count", 64'(err_count), 64'(pend.err));
            check("word_count", 64'(word_count), 64'(pend.wc));
            pending = 1'b0;
        end
        if (!reset && bus.c_srdy && bus.c_drdy) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_xfer", 64'd1, 64'd0);
            end else begin
                pend = sb.pop_front();
                check("xfer_data", 64'(bus.c_data), 64'(pend.w));
                pending = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        pending = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        count = 32'd0;
        drdy_pat = 8'hFF;
        bus.c_srdy = 1'b0;
        bus.c_data = 8'd0;

        do_reset();
        @(negedge clk);
        chk_idle("reset");

        // alternating throttle: 4 words in 7 RUN cycles
        drdy_pat = 8'b0101_0101;
        for (int i = 1; i <= 4; i++) add_word(8'(i));
        run_cmd(4, 4, 1'b0, 1'b1, 1'b0, cyc);
        check("pat55_cycles", 64'(cyc), 64'd7);

        // full throttle: 5 words on consecutive cycles
        do_reset();
        drdy_pat = 8'hFF;
        for (int i = 1; i <= 5; i++) add_word(8'(i));
        run_cmd(5, 5, 1'b0, 1'b0, 1'b0, cyc);
        check("ff_cycles", 64'(cyc), 64'd5);
        check("ff_err", 64'(err_count), 64'd0);
        check("ff_wc", 64'(word_count), 64'd5);

        // one gap in the sequence costs one error, then resync
        do_reset();
        add_word(8'd1); add_word(8'd2); add_word(8'd7); add_word(8'd8); add_word(8'd9);
        run_cmd(5, 5, 1'b0, 1'b0, 1'b0, cyc);
        check("gap_err", 64'(err_count), 64'd1);

        // position expected at FE, then wrap through FF to 00
        add_word(8'hFD);
        run_cmd(1, 1, 1'b0, 1'b0, 1'b0, cyc);
        check("pre_wrap_err", 64'(err_count), 64'd2);
        add_word(8'hFE); add_word(8'hFF); add_word(8'h00);
        run_cmd(3, 3, 1'b0, 1'b0, 1'b0, cyc);
        check("wrap_err", 64'(err_count), 64'd2);

        // zero-length command
        @(posedge clk); #1;
        start = 1'b1;
        count = 32'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_drdy", 64'(bus.c_drdy), 64'd0);
        check("zero_busy", 64'(busy), 64'd0);
        @(negedge clk);
        check("zero_done_clear", 64'(done), 64'd0);
        check("zero_drdy_after", 64'(bus.c_drdy), 64'd0);

        // start while in RUN must not reload remaining
        add_word(8'h01); add_word(8'h02); add_word(8'h03);
        run_cmd(3, 3, 1'b0, 1'b0, 1'b1, cyc);
        check("dbl_err", 64'(err_count), 64'd2);

        // random srdy stalls with an uneven throttle and occasional bad words
        drdy_pat = 8'hA5;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 3) == 0) add_word(8'($urandom));
            else add_word(m_exp);
        end
        run_cmd(12, 12, 1'b1, 1'b0, 1'b0, cyc);
        check("stall_err", 64'(err_count), 64'(m_err));
        check("stall_wc", 64'(word_count), 64'(m_wc));

        // reset mid-command aborts without done
        do_reset();
        drdy_pat = 8'hFF;
        for (int i = 1; i <= 6; i++) add_word(8'(i));
        run_cmd(6, 2, 1'b0, 1'b0, 1'b0, cyc);
        do_reset();
        @(negedge clk);
        chk_idle("abort");
        for (int i = 1; i <= 3; i++) add_word(8'(i));
        run_cmd(3, 3, 1'b0, 1'b0, 1'b0, cyc);
        check("abort_restart_err", 64'(err_count), 64'd0);
        check("abort_restart_wc", 64'(word_count), 64'd3);
        check("sb_drained", 64'(sb.size()), 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
